// File: rtl/apb4_master_bridge.sv
// APB4 requester bridge: valid/ready command in, APB4 SETUP/ACCESS out, buffered response back.
// Optional ACCESS-phase watchdog is built only when APB4_TIMEOUT_EN is defined.
module apb4_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLV        = 3,
  parameter int SLV_SEL_LSB    = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0]           cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]         cmd_strb,
  input  logic [2:0]                      cmd_prot,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [NUM_SLV-1:0]              PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  output logic [2:0]                      PPROT,
  input  logic [NUM_SLV-1:0]              PREADY,
  input  logic [NUM_SLV*DATA_WIDTH-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]              PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]      cmd_idx;
  logic                  idx_ok;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout;

  logic [NUM_SLV-1:0]    psel_d;
  logic                  penable_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [STRB_W-1:0]     pstrb_d;
  logic [2:0]            pprot_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_err_d;

  assign cmd_idx   = cmd_addr[SLV_SEL_LSB +: IDX_W];
  assign idx_ok    = (int'(cmd_idx) < NUM_SLV);
  assign cmd_ready = (state == IDLE);

  // Completer return path: the registered one-hot PSEL masks out every unselected slave.
  always_comb begin
    sel_ready = |(PREADY & PSEL);
    sel_err   = |(PSLVERR & PSEL);
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      sel_rdata = sel_rdata | (PRDATA[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{PSEL[k]}});
    end
  end

`ifdef APB4_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Watchdog: cleared while in SETUP, counts ACCESS cycles that see no PREADY.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !sel_ready) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end

  // Fires on the edge that would bring the count to TIMEOUT_CYCLES; a same-edge PREADY wins.
  assign timeout = (state == ACCESS) && !sel_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: ACCESS waits for PREADY indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = idx_ok ? SETUP : RESP;
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (sel_ready || timeout) begin
          state_next = RESP;
        end else begin
          state_next = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next values of the registered APB and response outputs; anything not touched holds.
  always_comb begin
    psel_d      = PSEL;
    penable_d   = PENABLE;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    pstrb_d     = PSTRB;
    pprot_d     = PPROT;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid && idx_ok) begin
          psel_d    = NUM_SLV'(1) << cmd_idx;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          pprot_d   = cmd_prot;
        end else if (cmd_valid) begin
          // Decode miss: answer directly without touching the APB bus.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (sel_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (PWRITE || sel_err) ? '0 : sel_rdata;
        end else if (timeout) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          penable_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        psel_d      = '0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PPROT     <= pprot_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Randomized bench for apb4_master_bridge: three memory-like completers with registered PREADY
// and a word-array reference model computing every expected response.
module tb_apb4_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA;
  logic [2:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [2:0]  PREADY, PSLVERR;
  logic [95:0] PRDATA;

`ifdef APB4_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  apb4_master_bridge dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Completer models: word 63 of each slave answers PSLVERR; unselected slaves babble.
  logic [31:0] smem [3][64];
  int          wait_left [3];
  int          slv_wait = 0;
  bit          slv_init = 1'b0;

  always @(posedge PCLK) begin
    if (!slv_init) begin
      for (int k = 0; k < 3; k++) begin
        PREADY[k] <= 1'b0; PSLVERR[k] <= 1'b0; PRDATA[k*32 +: 32] <= 32'h0; wait_left[k] <= 0;
        for (int w = 0; w < 64; w++) smem[k][w] <= 32'h0;
      end
      slv_init <= 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (PSEL[k] && !PENABLE) begin
          PREADY[k] <= 1'b0; wait_left[k] <= slv_wait;
          PSLVERR[k] <= 1'($urandom); PRDATA[k*32 +: 32] <= $urandom;
        end else if (PSEL[k] && PENABLE && PREADY[k]) begin
          PREADY[k] <= 1'b0; PSLVERR[k] <= 1'($urandom); PRDATA[k*32 +: 32] <= $urandom;
        end else if (PSEL[k] && PENABLE && wait_left[k] != 0) begin
          PREADY[k] <= 1'b0; wait_left[k] <= wait_left[k] - 1;
          PSLVERR[k] <= 1'($urandom); PRDATA[k*32 +: 32] <= $urandom;
        end else if (PSEL[k] && PENABLE) begin
          PREADY[k] <= 1'b1;
          if (PADDR[7:2] == 6'h3F) begin
            PSLVERR[k] <= 1'b1; PRDATA[k*32 +: 32] <= 32'h0;
          end else begin
            PSLVERR[k] <= 1'b0;
            PRDATA[k*32 +: 32] <= PWRITE ? $urandom : smem[k][PADDR[7:2]];
            if (PWRITE) begin
              for (int b = 0; b < 4; b++)
                if (PSTRB[b]) smem[k][PADDR[7:2]][8*b +: 8] <= PWDATA[8*b +: 8];
            end
          end
        end else begin
          PREADY[k] <= 1'($urandom); PSLVERR[k] <= 1'($urandom); PRDATA[k*32 +: 32] <= $urandom;
        end
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [3][64];
  logic [31:0] last_addr;
  logic [3:0]  last_strb;

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int wt, input int hold);
    int          idx, word, cyc, exp_cyc;
    logic        exp_err, timed_out, ok;
    logic [31:0] exp_rd;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_psel;
    idx = int'(addr[9:8]);
    word = int'(addr[7:2]);
    exp_strb = wr ? st : 4'h0;
    exp_cyc = 2 + wt;
    timed_out = TO_EN && (exp_cyc > 16);
    if (timed_out) exp_cyc = 16;
    exp_rd = 32'h0;
    exp_psel = 3'b000;
    if (idx >= 3) begin
      exp_err = 1'b1;
    end else begin
      exp_psel[idx] = 1'b1;
      exp_err = timed_out || (word == 63);
      if (!exp_err && wr) begin
        for (int b = 0; b < 4; b++) if (st[b]) ref_mem[idx][word][8*b +: 8] = wd[8*b +: 8];
      end else if (!exp_err) begin
        exp_rd = ref_mem[idx][word];
      end
    end
    slv_wait = wt;

    @(negedge PCLK);
    check_val("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);

    if (idx < 3) begin
      ok = (PSEL === exp_psel) && (PENABLE === 1'b0) && (PADDR === addr) && (PWRITE === wr)
        && (PWDATA === wd) && (PSTRB === exp_strb) && (PPROT === pr) && (rsp_valid === 1'b0);
      check_val("setup_phase", ok, 1);
      check_val("setup_psel", PSEL, exp_psel);
      cyc = 0;
      @(negedge PCLK);
      while (rsp_valid !== 1'b1 && cyc < 64) begin
        cyc++;
        ok = (PSEL === exp_psel) && (PENABLE === 1'b1) && (PADDR === addr) && (PWRITE === wr)
          && (PWDATA === wd) && (PSTRB === exp_strb) && (PPROT === pr) && (cmd_ready === 1'b0);
        check_val("access_hold", ok, 1);
        @(negedge PCLK);
      end
      check_val("access_cycles", cyc, exp_cyc);
      last_addr = addr;
      last_strb = exp_strb;
    end
    check_val("rsp_bus_idle", {PSEL, PENABLE}, 4'b0000);
    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("rsp_rdata", rsp_rdata, exp_rd);

    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      check_val("rsp_hold", {rsp_valid, cmd_ready, PSEL, rsp_err, rsp_rdata},
                {1'b1, 1'b0, 3'b000, exp_err, exp_rd});
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check_val("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    check_val("idle_bus", {PSEL, PENABLE, PADDR, PSTRB}, {3'b000, 1'b0, last_addr, last_strb});
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  ridx;
    logic [5:0]  rword;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; cmd_prot = 3'd0; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) for (int w = 0; w < 64; w++) ref_mem[k][w] = 32'h0;
    last_addr = 32'h0; last_strb = 4'h0;
    repeat (3) @(negedge PCLK);
    check_val("reset_outputs", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT},
              {3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 3'd0});
    check_val("reset_rsp", {rsp_valid, rsp_err, rsp_rdata, cmd_ready}, {1'b0, 1'b0, 32'h0, 1'b1});
    PRESET = 1'b0;

    // Directed sequence.
    run_txn(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 0);
    run_txn(1'b0, 32'h0000_0004, 32'h0,        4'hF, 3'd0, 0, 1);
    run_txn(1'b1, 32'h0000_0108, 32'h1122_3344, 4'h3, 3'd5, 0, 0);
    run_txn(1'b0, 32'h0000_0108, 32'h0,        4'h0, 3'd0, 1, 0);
    run_txn(1'b0, 32'h0000_0300, 32'h0,        4'h0, 3'd0, 0, 5);
    run_txn(1'b1, 32'h0000_02FC, 32'h5555_AAAA, 4'hF, 3'd1, 2, 0);
`ifdef APB4_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0204, 32'h0, 4'h0, 3'd0, 30, 1);
    run_txn(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, 3'd0, 14, 0);
`endif

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      r = $urandom;
      ridx = 2'($urandom_range(3, 0));
      rword = ($urandom_range(7, 0) == 0) ? 6'h3F : 6'($urandom_range(15, 0));
      run_txn(1'($urandom), {r[31:10], ridx, rword, 2'b00}, $urandom, 4'($urandom),
              3'($urandom), $urandom_range(3, 0), $urandom_range(2, 0));
    end

    // Reset in the middle of an ACCESS wait drops the command.
    slv_wait = 6;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_prot = 3'd0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check_val("pre_reset_access", {PSEL, PENABLE}, 4'b0011);
    PRESET = 1'b1;
    #1;
    check_val("async_reset_bus", {PSEL, PENABLE, rsp_valid}, 5'b00000);
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      check_val("no_rsp_after_reset", {rsp_valid, PSEL, cmd_ready}, 5'b00001);
    end
    last_addr = 32'h0; last_strb = 4'h0;
    run_txn(1'b0, 32'h0000_0108, 32'h0, 4'h0, 3'd0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 requester (bridge) that turns a simple valid/ready command interface into APB4 SETUP/ACCESS transfers toward up to NUM_SLV completer slaves, such as the team's APB4 memory slaves.
- Decodes one PSEL line per slave from an address field.
- Waits on PREADY, then returns PRDATA and PSLVERR through a buffered valid/ready response channel.
- Sits between the system-side command source and the APB4 slave fabric.

Parameters:
DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width = DATA_WIDTH/8
ADDR_WIDTH, 32, PADDR width
NUM_SLV, 3, number of slaves; PSEL width
SLV_SEL_LSB, 8, LSB of slave-index field; index = cmd_addr[SLV_SEL_LSB +: $clog2(NUM_SLV)]
TIMEOUT_CYCLES, 16, ACCESS-phase watchdog limit (used only with APB4_TIMEOUT_EN)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR, decode error or timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  ACCESS-phase indicator
PWRITE  out  1  direction
PWDATA  out  DATA_WIDTH  write data
PSTRB  out  DATA_WIDTH/8  write strobes
PPROT  out  3  protection
PREADY  in  NUM_SLV  per-slave ready
PRDATA  in  NUM_SLV*DATA_WIDTH  per-slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
PSLVERR  in  NUM_SLV  per-slave error

Behaviour:
- The clock and reset are PCLK and PRESET: one clock, asynchronous active-high reset.
- All APB outputs and response outputs are registered.

Reset (PRESET high):
- State returns to IDLE immediately.
- PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata and rsp_err all go to 0.
- Reset mid-transfer drops the outstanding command and produces no response.

FSM states are IDLE, SETUP, ACCESS and RESP.

IDLE:
- cmd_ready = 1 combinationally; it is 0 in every other state.
- On edge E with cmd_valid=1, latch addr/wdata/strb/prot/write and compute the slave index.
- Index >= NUM_SLV (decode error): go to RESP with rsp_err=1 and rsp_rdata=0. No APB activity occurs.
- Valid index: go to SETUP. From edge E, PSEL[idx]=1, PENABLE=0, and PADDR/PWRITE/PWDATA/PPROT are driven.
- PSTRB = cmd_strb for writes and is forced to 0 for reads (APB4 rule).

SETUP:
- Lasts exactly one cycle.
- On the next edge, PENABLE is set to 1 and the state moves to ACCESS.

ACCESS:
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are held stable.
- At each edge, sample PREADY[idx]. While it is 0, stay in ACCESS (unbounded wait unless APB4_TIMEOUT_EN is defined).
- When it is 1: capture rsp_err=PSLVERR[idx] and rsp_rdata = read ? PRDATA slice[idx] : 0. Clear PSEL and PENABLE, set rsp_valid=1 and go to RESP.
- PREADY, PRDATA and PSLVERR of unselected slaves, and all three in any state other than ACCESS, are ignored.

RESP:
- rsp_valid, rsp_rdata and rsp_err are held until rsp_ready=1.
- On that edge, rsp_valid goes to 0 and the state returns to IDLE.
- A new command cannot be accepted in the same cycle as the response handshake.

Timing and outputs between transfers:
- Minimum transfer with a zero-wait slave is 4 cycles from acceptance to IDLE: SETUP, ACCESS, RESP, then IDLE.
- The codebase's memory slaves register PREADY, so ACCESS lasts 2 cycles with them.
- Between transfers, PADDR/PWRITE/PWDATA/PPROT keep their last values; PSTRB keeps its last value; PSEL and PENABLE are 0.

Optional Feature:
APB4_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle while PREADY[idx]=0.
- When the count reaches TIMEOUT_CYCLES, the transfer is aborted: PSEL and PENABLE clear, rsp_err=1, rsp_rdata=0, and the state goes to RESP.
- A PREADY arriving on the same edge as the timeout wins (normal completion).
- Undefined: no counter logic exists and ACCESS waits indefinitely.

Test Plan:
- Write: addr 0x0000_0004, wdata 0xDEADBEEF, strb 0xF, slave 0 with registered PREADY -> SETUP 1 cycle (PSEL=3'b001, PENABLE=0), ACCESS 2 cycles, PSTRB=0xF, rsp_valid with rsp_err=0, rsp_rdata=0.
- Read back addr 0x0000_0004 -> PSTRB=0, PWRITE=0, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial write: 0x1122_3344 with strb 0x3 to addr 0x0000_0108 (slave 1, PSEL=3'b010), then read it back -> rsp_rdata=0x0000_3344 (masked slave).
- Decode error: addr 0x0000_0300 (index 3) -> PSEL stays 0 throughout, rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Hold rsp_ready=0 for 5 cycles after a response -> rsp_valid, rsp_rdata and rsp_err stable and cmd_ready=0 until the handshake; assert PRESET during a later ACCESS -> PSEL/PENABLE are 0 immediately and no rsp_valid follows.
- With APB4_TIMEOUT_EN, hold PREADY=0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0, PSEL=0.
